// File: rtl/find_max_datapath_if.sv
// Memory read bus between the findMax datapath and its single-port block ROM.
// The datapath is the master: it drives the address and consumes the read data.
interface find_max_datapath_if #(
    parameter int AW = 8,
    parameter int DW = 16
) ();
    logic [AW-1:0] addra;
    logic [DW-1:0] douta;

    modport master (output addra, input  douta);
    modport slave  (input  addra, output douta);
endinterface

// File: rtl/find_max_datapath.sv
// findMax datapath: walks n consecutive ROM words from startaddr and keeps the
// unsigned running maximum; done is sticky once every requested word is compared.
module find_max_datapath #(
    parameter int AW  = 8,
    parameter int DW  = 16,
    parameter int SAW = 16
) (
    input  logic                mclk,
    input  logic                reset,
    input  logic [SAW-1:0]      startaddr,
    input  logic [AW-1:0]       n,
    find_max_datapath_if.master mem,
    output logic [DW-1:0]       max,
    output logic                done
);
    localparam logic [AW-1:0] ONE_A = AW'(1);

    logic [AW-1:0] addr_r;
    logic [AW-1:0] addr_s;
    logic [AW-1:0] remaining_r;
    logic [AW-1:0] remaining_s;
    logic          vld_r;
    logic          vld_s;
    logic [DW-1:0] max_r;
    logic [DW-1:0] max_s;
    logic          done_r;
    logic          done_s;

    // Upper startaddr bits are intentionally ignored; the address space is AW bits.
    logic unused_startaddr_s;
    assign unused_startaddr_s = ^startaddr[SAW-1:AW];

    // Next-state: issue one read per cycle while words remain, compare the word
    // requested on the previous edge (the ROM has one cycle of latency).
    always_comb begin
        addr_s      = addr_r;
        remaining_s = remaining_r;
        vld_s       = 1'b0;
        max_s       = max_r;
        done_s      = done_r;
        if (remaining_r != '0) begin
            addr_s      = addr_r + ONE_A;
            remaining_s = remaining_r - ONE_A;
            vld_s       = 1'b1;
        end else begin
            done_s      = 1'b1;
        end
        if (vld_r && (mem.douta > max_r)) begin
            max_s = mem.douta;
        end else begin
            max_s = max_r;
        end
    end

    // State registers; reset samples the scan parameters and clears results.
    always_ff @(posedge mclk) begin
        if (reset) begin
            addr_r      <= startaddr[AW-1:0];
            remaining_r <= n;
            vld_r       <= 1'b0;
            max_r       <= '0;
            done_r      <= 1'b0;
        end else begin
            addr_r      <= addr_s;
            remaining_r <= remaining_s;
            vld_r       <= vld_s;
            max_r       <= max_s;
            done_r      <= done_s;
        end
    end

    assign mem.addra = addr_r;
    assign max       = max_r;
    assign done      = done_r;
endmodule

// File: tb/tb_find_max_datapath.sv
// Directed bench for find_max_datapath: ROM model, per-cycle address checks and
// a scoreboard that checks final max/addra/latency when done rises.
module tb_find_max_datapath;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] startaddr = 16'h0000;
    logic [7:0]  n = 8'd0;
    logic [15:0] max;
    logic        done;
    logic [15:0] mem [256];

    find_max_datapath_if #(.AW(8), .DW(16)) mif ();

    find_max_datapath #(.AW(8), .DW(16), .SAW(16)) dut (
        .mclk      (clk),
        .reset     (reset),
        .startaddr (startaddr),
        .n         (n),
        .mem       (mif.master),
        .max       (max),
        .done      (done)
    );

    always #5 clk = ~clk;

    // ROM: one-cycle read latency, no output register
    always @(posedge clk) mif.douta <= mem[mif.addra];

    typedef struct {
        logic [15:0] emax;
        logic [7:0]  eaddr;
        int          eedge;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int errs  = 0;
    int ecnt  = 0;
    bit done_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // edge counter since reset release
    always @(posedge clk) begin
        if (reset) ecnt <= 0;
        else       ecnt <= ecnt + 1;
    end

    // monitor: pop one expected result when done rises
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            done_seen = 1'b0;
        end else if (done && !done_seen) begin
            done_seen = 1'b1;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("final_max", {16'h0, max}, {16'h0, e.emax});
                check("final_addra", {24'h0, mif.addra}, {24'h0, e.eaddr});
                check("done_edge", ecnt, e.eedge);
            end
        end
    end

    task automatic apply_reset(input logic [15:0] sa, input logic [7:0] nn, input int cyc);
        @(negedge clk);
        reset = 1'b1;
        startaddr = sa;
        n = nn;
        repeat (cyc) @(negedge clk);
        check("rst_max", {16'h0, max}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_addra", {24'h0, mif.addra}, {24'h0, sa[7:0]});
    endtask

    task automatic run_scan(input logic [15:0] sa, input logic [7:0] nn, input int cyc,
                            input logic [15:0] emax, input logic [7:0] eaddr);
        exp_t e;
        logic [7:0] a;
        apply_reset(sa, nn, cyc);
        e.emax = emax; e.eaddr = eaddr; e.eedge = int'(nn) + 1;
        sb.push_back(e);
        reset = 1'b0;
        for (int k = 1; k <= int'(nn) + 1; k++) begin
            @(negedge clk);
            a = sa[7:0] + ((k < int'(nn)) ? 8'(k) : nn);
            check("addra_seq", {24'h0, mif.addra}, {24'h0, a});
        end
        // results must hold after the scan
        repeat (3) @(negedge clk);
        check("hold_max", {16'h0, max}, {16'h0, emax});
        check("hold_done", {31'h0, done}, 32'h1);
        check("hold_addra", {24'h0, mif.addra}, {24'h0, eaddr});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;

        // basic two-word scan
        mem[0] = 16'h0005; mem[1] = 16'h0012;
        run_scan(16'h0000, 8'd2, 10, 16'h0012, 8'h02);

        // unsigned compare across the sign bit
        mem[3] = 16'h0010; mem[4] = 16'h8001; mem[5] = 16'h0002; mem[6] = 16'h7FFF;
        run_scan(16'h0003, 8'd4, 2, 16'h8001, 8'h07);

        // empty scan
        mem[8'h20] = 16'hAAAA;
        run_scan(16'h0020, 8'd0, 2, 16'h0000, 8'h20);

        // address wrap
        mem[8'hFE] = 16'h0001; mem[8'hFF] = 16'h0002; mem[8'h00] = 16'hFFFF;
        run_scan(16'h00FE, 8'd3, 2, 16'hFFFF, 8'h01);

        // re-run then re-reset with upper startaddr bits set
        mem[0] = 16'h0005;
        run_scan(16'h0000, 8'd2, 2, 16'h0012, 8'h02);
        run_scan(16'h0103, 8'd4, 2, 16'h8001, 8'h07);

        // abort mid-scan: reset sampled at edge 3 of an n=4 scan
        apply_reset(16'h0003, 8'd4, 2);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_max", {16'h0, max}, 32'h0010);
        check("mid_done", {31'h0, done}, 32'h0);
        mem[8'h10] = 16'h0042;
        reset = 1'b1;
        startaddr = 16'h0010;
        n = 8'd1;
        @(negedge clk);
        check("abort_max", {16'h0, max}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        check("abort_addra", {24'h0, mif.addra}, 32'h10);
        run_scan(16'h0010, 8'd1, 1, 16'h0042, 8'h11);

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", tests, errs);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
